// File: rtl/jstk2_txn_scheduler_if.sv
// ---------------------------------------------------------------------------
// jstk2_txn_scheduler_if
// Bundles the JSTK2 SPI pins, the LED-write handshake and the position
// result bus of jstk2_txn_scheduler.
//   master : the scheduler (drives SS/SCLK/MOSI, led_ack, busy, results)
//   slave  : user logic / joystick side (drives MISO, led_req, led_r/g/b)
// Signals:
//   MISO        JSTK2 serial data out
//   SS          slave select, active low
//   SCLK        SPI clock, mode 0
//   MOSI        SPI data to JSTK2
//   led_req     LED write request, level, held until led_ack
//   led_r/g/b   LED colour, captured on led_ack
//   led_ack     one-cycle pulse: LED transaction accepted
//   busy        high from transaction start through end of POST
//   x_val/y_val 10-bit stick position
//   buttons     bit1 trigger, bit0 stick
//   data_valid  one-cycle pulse when x_val/y_val/buttons update
// ---------------------------------------------------------------------------
interface jstk2_txn_scheduler_if;
    logic       MISO;
    logic       SS;
    logic       SCLK;
    logic       MOSI;
    logic       led_req;
    logic [7:0] led_r;
    logic [7:0] led_g;
    logic [7:0] led_b;
    logic       led_ack;
    logic       busy;
    logic [9:0] x_val;
    logic [9:0] y_val;
    logic [1:0] buttons;
    logic       data_valid;

    modport master (
        input  MISO, led_req, led_r, led_g, led_b,
        output SS, SCLK, MOSI, led_ack, busy, x_val, y_val, buttons, data_valid
    );

    modport slave (
        output MISO, led_req, led_r, led_g, led_b,
        input  SS, SCLK, MOSI, led_ack, busy, x_val, y_val, buttons, data_valid
    );
endinterface

// File: rtl/jstk2_txn_scheduler.sv
// ---------------------------------------------------------------------------
// jstk2_txn_scheduler
// Pmod JSTK2 transaction controller. Generates SS/SCLK/MOSI with the JSTK2
// inter-byte and post-transaction gaps, and arbitrates between a periodic
// position poll and an RGB LED write (LED has priority). Every transaction
// clocks in five bytes; the position fields are published with a one-cycle
// data_valid strobe when SS rises.
// Ports:
//   clk  system clock (100 MHz)
//   rst  asynchronous, active-low reset
//   bus  jstk2_txn_scheduler_if.master (SPI pins, LED handshake, results)
// ---------------------------------------------------------------------------
module jstk2_txn_scheduler #(
    parameter int SCLK_HALF   = 750,
    parameter int PRE_SS      = 1500,
    parameter int INTER_BYTE  = 1000,
    parameter int POST_SS     = 2500,   // must be >= 2
    parameter int POLL_PERIOD = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    jstk2_txn_scheduler_if.master  bus
);

    localparam int M1      = (PRE_SS > INTER_BYTE) ? PRE_SS : INTER_BYTE;
    localparam int M2      = (POST_SS > 2 * SCLK_HALF) ? POST_SS : 2 * SCLK_HALF;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int POLL_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_SS - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(SCLK_HALF - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(2 * SCLK_HALF - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(INTER_BYTE - 1);
    // POST is one cycle shorter than POST_SS: the IDLE arbitration cycle
    // completes the SS-high window, so a queued transaction drops SS exactly
    // POST_SS cycles after the previous SS rise.
    localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_SS - 2);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        POST  = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [2:0]          bit_reg, bit_next;
    logic [2:0]          byte_reg, byte_next;
    logic [39:0]         tx_reg, tx_next;
    logic [39:0]         rx_reg, rx_next;
    logic [POLL_W-1:0]   poll_cnt_reg, poll_cnt_next;
    logic                poll_pending_reg, poll_pending_next;
    logic                ss_reg, ss_next;
    logic                sclk_reg, sclk_next;
    logic                mosi_reg, mosi_next;
    logic                ack_reg, ack_next;
    logic                busy_reg, busy_next;
    logic [9:0]          x_reg, x_next;
    logic [9:0]          y_reg, y_next;
    logic [1:0]          btn_reg, btn_next;
    logic                dv_reg, dv_next;
    logic                poll_wrap;
    logic                poll_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            bit_reg          <= '0;
            byte_reg         <= '0;
            tx_reg           <= '0;
            rx_reg           <= '0;
            poll_cnt_reg     <= '0;
            poll_pending_reg <= 1'b0;
            ss_reg           <= 1'b1;
            sclk_reg         <= 1'b0;
            mosi_reg         <= 1'b0;
            ack_reg          <= 1'b0;
            busy_reg         <= 1'b0;
            x_reg            <= '0;
            y_reg            <= '0;
            btn_reg          <= '0;
            dv_reg           <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            bit_reg          <= bit_next;
            byte_reg         <= byte_next;
            tx_reg           <= tx_next;
            rx_reg           <= rx_next;
            poll_cnt_reg     <= poll_cnt_next;
            poll_pending_reg <= poll_pending_next;
            ss_reg           <= ss_next;
            sclk_reg         <= sclk_next;
            mosi_reg         <= mosi_next;
            ack_reg          <= ack_next;
            busy_reg         <= busy_next;
            x_reg            <= x_next;
            y_reg            <= y_next;
            btn_reg          <= btn_next;
            dv_reg           <= dv_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        byte_next     = byte_reg;
        tx_next       = tx_reg;
        rx_next       = rx_reg;
        ss_next       = ss_reg;
        sclk_next     = sclk_reg;
        mosi_next     = mosi_reg;
        ack_next      = 1'b0;
        busy_next     = busy_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        btn_next      = btn_reg;
        dv_next       = 1'b0;
        poll_start    = 1'b0;

        poll_wrap     = (poll_cnt_reg == POLL_LAST);
        poll_cnt_next = poll_wrap ? '0 : poll_cnt_reg + POLL_W'(1);

        case (state_reg)
            IDLE: begin
                if (bus.led_req) begin
                    state_next = PRE;
                    cnt_next   = '0;
                    byte_next  = '0;
                    ss_next    = 1'b0;
                    busy_next  = 1'b1;
                    ack_next   = 1'b1;
                    tx_next    = {8'h84, bus.led_r, bus.led_g, bus.led_b, 8'h00};
                end else if (poll_pending_reg) begin
                    state_next = PRE;
                    cnt_next   = '0;
                    byte_next  = '0;
                    ss_next    = 1'b0;
                    busy_next  = 1'b1;
                    poll_start = 1'b1;
                    tx_next    = '0;
                end
            end

            PRE: begin
                if (cnt_reg == PRE_LAST) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    bit_next   = '0;
                    mosi_next  = tx_reg[39];
                    tx_next    = {tx_reg[38:0], 1'b0};
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            SHIFT: begin
                if (cnt_reg == HALF_LAST) begin
                    // Rising SCLK: the slave's bit has been stable for the
                    // whole low half, capture it on this same edge.
                    sclk_next = 1'b1;
                    rx_next   = {rx_reg[38:0], bus.MISO};
                    cnt_next  = cnt_reg + CNT_W'(1);
                end else if (cnt_reg == BIT_LAST) begin
                    sclk_next = 1'b0;
                    cnt_next  = '0;
                    if (bit_reg != 3'd7) begin
                        bit_next  = bit_reg + 3'd1;
                        mosi_next = tx_reg[39];
                        tx_next   = {tx_reg[38:0], 1'b0};
                    end else if (byte_reg == 3'd4) begin
                        state_next = POST;
                        ss_next    = 1'b1;
                        mosi_next  = 1'b0;
                        x_next     = {rx_reg[25:24], rx_reg[39:32]};
                        y_next     = {rx_reg[9:8], rx_reg[23:16]};
                        btn_next   = rx_reg[1:0];
                        dv_next    = 1'b1;
                    end else begin
                        state_next = GAP;
                        byte_next  = byte_reg + 3'd1;
                        mosi_next  = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    bit_next   = '0;
                    mosi_next  = tx_reg[39];
                    tx_next    = {tx_reg[38:0], 1'b0};
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            POST: begin
                if (cnt_reg == POST_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                ss_next    = 1'b1;
                sclk_next  = 1'b0;
                mosi_next  = 1'b0;
                busy_next  = 1'b0;
            end
        endcase

        // A wrap wins over a same-cycle poll start so the new request is
        // kept for the following transaction.
        if (poll_wrap) begin
            poll_pending_next = 1'b1;
        end else if (poll_start) begin
            poll_pending_next = 1'b0;
        end else begin
            poll_pending_next = poll_pending_reg;
        end
    end

    assign bus.SS         = ss_reg;
    assign bus.SCLK       = sclk_reg;
    assign bus.MOSI       = mosi_reg;
    assign bus.led_ack    = ack_reg;
    assign bus.busy       = busy_reg;
    assign bus.x_val      = x_reg;
    assign bus.y_val      = y_reg;
    assign bus.buttons    = btn_reg;
    assign bus.data_valid = dv_reg;

endmodule
